// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder built around a single full adder, one bit pair per clock
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    // One-bit sum and majority carry
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // One extra bit keeps the counter non-degenerate when WIDTH is 1
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] psum;
    logic [WIDTH-1:0] psum_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             last_bit;
    logic             fa_s;
    logic             fa_cout;

    full_adder u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_cout)
    );

    assign last_bit = (cnt == CW'(WIDTH - 1));

    // busy/done come straight from the state register, so they never depend on inputs
    assign busy = (state == RUN);
    assign done = (state == DONE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a start is honoured only from IDLE or DONE, never mid-RUN
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Partial sum after this cycle's bit; written bitwise so WIDTH=1 needs no special case
    always_comb begin
        psum_next            = psum >> 1;
        psum_next[WIDTH-1]   = fa_s;
    end

    // Operand/carry/partial-sum datapath and the result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            psum  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            psum  <= '0;
            carry <= cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            psum  <= psum_next;
            carry <= fa_cout;
            cnt   <= cnt + CW'(1);
            if (last_bit) begin
                sum  <= psum_next;
                cout <= fa_cout;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed self-checking bench for serial_adder
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       cin1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one WIDTH=8 addition and follow it edge by edge; noise=1 toggles start with a=FF mid-RUN
    task automatic add8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                        input logic [7:0] es, input logic ec, input bit noise, input string tag);
        a     = ta;
        b     = tb;
        cin   = tc;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        cin   = 1'b0;
        check({tag, " busy_after_start"}, {31'd0, busy}, 32'd1);
        for (int k = 1; k <= 8; k++) begin
            if (noise) begin
                start = (k >= 1 && k <= 4);
                a     = (k >= 1 && k <= 4) ? 8'hFF : 8'h00;
            end
            tick();
            if (k < 8) begin
                if (busy !== 1'b1 || done !== 1'b0)
                    check({tag, " run_busy_done"}, {30'd0, busy, done}, 32'd2);
            end
        end
        check({tag, " done"}, {31'd0, done}, 32'd1);
        check({tag, " busy_low"}, {31'd0, busy}, 32'd0);
        check({tag, " sum"}, {24'd0, sum}, {24'd0, es});
        check({tag, " cout"}, {31'd0, cout}, {31'd0, ec});
        tick();
        check({tag, " done_one_cycle"}, {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        a      = 8'h00;
        b      = 8'h00;
        cin    = 1'b0;
        start1 = 1'b0;
        a1     = 1'b0;
        b1     = 1'b0;
        cin1   = 1'b0;

        // Reset state, with start asserted alongside reset to show reset wins
        tick();
        start = 1'b1;
        a     = 8'h55;
        tick();
        start = 1'b0;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_sum", {24'd0, sum}, 32'd0);
        check("reset_cout", {31'd0, cout}, 32'd0);
        rst = 1'b0;
        tick();

        // Directed additions
        add8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "ff_01");
        add8(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0, "a5_5a_c");
        add8(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, "00_00_c");
        add8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b1, "start_in_run");
        tick();
        check("no_extra_add", {30'd0, busy, done}, 32'd0);

        // Reset on the fourth RUN cycle aborts the addition and clears the result
        a     = 8'h12;
        b     = 8'h34;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_sum", {24'd0, sum}, 32'd0);
        check("abort_cout", {31'd0, cout}, 32'd0);
        for (int k = 0; k < 10; k++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0)
                check("abort_no_done", {30'd0, busy, done}, 32'd0);
        end
        add8(8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0, "after_abort");

        // start held high: second addition launches from the DONE cycle
        a     = 8'h10;
        b     = 8'h20;
        cin   = 1'b0;
        start = 1'b1;
        tick();
        for (int k = 1; k <= 17; k++) begin
            tick();
            if (k == 8) begin
                check("held_done1", {31'd0, done}, 32'd1);
                check("held_sum1", {23'd0, cout, sum}, 32'h030);
                a = 8'hF0;
            end else if (k == 9) begin
                check("held_relaunch", {30'd0, busy, done}, 32'd2);
            end else if (k == 12) begin
                check("held_sum_hold", {23'd0, cout, sum}, 32'h030);
            end else if (k == 16) begin
                check("held_not_yet", {31'd0, done}, 32'd0);
            end else if (k == 17) begin
                check("held_done2", {31'd0, done}, 32'd1);
                check("held_sum2", {23'd0, cout, sum}, 32'h110);
                start = 1'b0;
            end
        end
        tick();
        check("held_stop", {30'd0, busy, done}, 32'd0);

        // WIDTH=1 instance, every input combination
        for (int v = 0; v < 8; v++) begin
            logic [2:0] vv;
            logic [1:0] exp1;
            vv     = 3'(v);
            a1     = vv[0];
            b1     = vv[1];
            cin1   = vv[2];
            exp1   = 2'(vv[0]) + 2'(vv[1]) + 2'(vv[2]);
            start1 = 1'b1;
            tick();
            start1 = 1'b0;
            check("w1_busy", {30'd0, busy1, done1}, 32'd2);
            tick();
            check("w1_done", {30'd0, busy1, done1}, 32'd1);
            check("w1_result", {30'd0, cout1, sum1}, {30'd0, exp1});
            tick();
        end

        // Random operands at WIDTH=8 against integer addition
        for (int r = 0; r < 40; r++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            logic       rc;
            logic [8:0] rs;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            rs = 9'(ra) + 9'(rb) + 9'(rc);
            add8(ra, rb, rc, rs[7:0], rs[8], 1'b0, "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
